// File: rtl/inst_queue.sv
// Multi-lane fetch-to-decode instruction queue: up to ENQ_NUM entries in and
// DEQ_NUM entries out per cycle, with decode pause and single-cycle flush.
module inst_queue #(
  parameter int DATA_WIDTH = 146,
  parameter int DEPTH      = 8,
  parameter int ENQ_NUM    = 2,
  parameter int DEQ_NUM    = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic                              pause,
  input  logic [ENQ_NUM-1:0]                enq_valid,
  input  logic [ENQ_NUM*DATA_WIDTH-1:0]     enq_data,
  output logic                              enq_ready,
  output logic [DEQ_NUM-1:0]                deq_valid,
  output logic [DEQ_NUM*DATA_WIDTH-1:0]     deq_data,
  input  logic [DEQ_NUM-1:0]                deq_ready,
  output logic [$clog2(DEPTH+1)-1:0]        count,
  output logic                              empty,
  output logic                              full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  // Length of the unbroken run of ones starting at bit 0 (lanes are at most 4).
  function automatic logic [2:0] run_len(input logic [3:0] vec);
    logic stop;
    run_len = 3'd0;
    stop    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!stop && vec[i]) begin
        run_len = run_len + 3'd1;
      end else begin
        stop = 1'b1;
      end
    end
  endfunction

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]      head_r, tail_r;
  logic [CNT_W-1:0]      count_r;
  logic                  enq_ready_r, empty_r, full_r;
  logic [DEQ_NUM-1:0]    deq_valid_r;

  logic [3:0]            enq_vec_s, deq_vec_s;
  logic [2:0]            n_enq_s, n_deq_s;
  logic [PTR_W-1:0]      head_nxt_s, tail_nxt_s;
  logic [CNT_W-1:0]      count_nxt_s;
  logic                  enq_ready_nxt_s, empty_nxt_s, full_nxt_s;
  logic [DEQ_NUM-1:0]    deq_valid_nxt_s;
  logic [PTR_W-1:0]      wr_idx_s [ENQ_NUM];
  logic [PTR_W-1:0]      rd_idx_s [DEQ_NUM];

  // Per-lane storage slots relative to the current pointers (wrap modulo DEPTH).
  always_comb begin
    for (int k = 0; k < ENQ_NUM; k++) begin
      wr_idx_s[k] = tail_r + PTR_W'(k);
    end
    for (int i = 0; i < DEQ_NUM; i++) begin
      rd_idx_s[i] = head_r + PTR_W'(i);
    end
  end

  // Transfer counts and next pointer/count state; flush overrides traffic.
  always_comb begin
    enq_vec_s                = 4'b0000;
    enq_vec_s[ENQ_NUM-1:0]   = enq_valid;
    deq_vec_s                = 4'b0000;
    deq_vec_s[DEQ_NUM-1:0]   = deq_valid_r & deq_ready;
    n_enq_s = enq_ready_r ? run_len(enq_vec_s) : 3'd0;
    n_deq_s = pause ? 3'd0 : run_len(deq_vec_s);
    if (flush) begin
      head_nxt_s  = '0;
      tail_nxt_s  = '0;
      count_nxt_s = '0;
    end else begin
      head_nxt_s  = head_r + PTR_W'(n_deq_s);
      tail_nxt_s  = tail_r + PTR_W'(n_enq_s);
      count_nxt_s = count_r + CNT_W'(n_enq_s) - CNT_W'(n_deq_s);
    end
  end

  // Status flags precomputed from the next count so the outputs come straight from flops.
  always_comb begin
    enq_ready_nxt_s = (count_nxt_s <= CNT_W'(DEPTH - ENQ_NUM));
    empty_nxt_s     = (count_nxt_s == CNT_W'(0));
    full_nxt_s      = (count_nxt_s == CNT_W'(DEPTH));
    for (int i = 0; i < DEQ_NUM; i++) begin
      deq_valid_nxt_s[i] = (count_nxt_s > CNT_W'(i));
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r      <= '0;
      tail_r      <= '0;
      count_r     <= '0;
      enq_ready_r <= 1'b1;
      empty_r     <= 1'b1;
      full_r      <= 1'b0;
      deq_valid_r <= '0;
    end else begin
      head_r      <= head_nxt_s;
      tail_r      <= tail_nxt_s;
      count_r     <= count_nxt_s;
      enq_ready_r <= enq_ready_nxt_s;
      empty_r     <= empty_nxt_s;
      full_r      <= full_nxt_s;
      deq_valid_r <= deq_valid_nxt_s;
    end
  end

  // Entry storage; intentionally not reset, and left untouched by flush.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      for (int k = 0; k < ENQ_NUM; k++) begin
        if (3'(k) < n_enq_s) begin
          mem_r[wr_idx_s[k]] <= enq_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // Read lanes: invalid lanes are forced to zero.
  always_comb begin
    deq_data = '0;
    for (int i = 0; i < DEQ_NUM; i++) begin
      if (deq_valid_r[i]) begin
        deq_data[i*DATA_WIDTH +: DATA_WIDTH] = mem_r[rd_idx_s[i]];
      end else begin
        deq_data[i*DATA_WIDTH +: DATA_WIDTH] = '0;
      end
    end
  end

  assign enq_ready = enq_ready_r;
  assign deq_valid = deq_valid_r;
  assign count     = count_r;
  assign empty     = empty_r;
  assign full      = full_r;

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: directed scenarios plus a randomized
// stream, all checked against a queue-based reference model.
module tb_inst_queue;

  localparam int DW = 146;
  localparam int DEPTH = 8;
  localparam int EN = 2;
  localparam int DN = 2;
  localparam int OW = 4 + 1 + 1 + 1 + DN + DN*DW;

  logic            clk = 1'b0;
  logic            rst, flush, pause;
  logic [EN-1:0]   enq_valid;
  logic [EN*DW-1:0] enq_data;
  logic            enq_ready;
  logic [DN-1:0]   deq_valid, deq_ready;
  logic [DN*DW-1:0] deq_data;
  logic [3:0]      count;
  logic            empty, full;
  logic [OW-1:0]   dut_obs;

  logic [DW-1:0]   mq[$];
  int              n_cmp = 0;
  int              n_err = 0;

  inst_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ENQ_NUM(EN), .DEQ_NUM(DN)) dut (
    .clk(clk), .rst(rst), .flush(flush), .pause(pause),
    .enq_valid(enq_valid), .enq_data(enq_data), .enq_ready(enq_ready),
    .deq_valid(deq_valid), .deq_data(deq_data), .deq_ready(deq_ready),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  assign dut_obs = {count, empty, full, enq_ready, deq_valid, deq_data};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  function automatic int lead(input logic [1:0] v);
    if (!v[0]) return 0;
    if (!v[1]) return 1;
    return 2;
  endfunction

  function automatic logic [DW-1:0] rnd();
    logic [159:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] val(input int i);
    logic [DW-1:0] v;
    v = DW'(i);
    v = v | (DW'(32'hA5A5_0000 + i) << 100);
    return v;
  endfunction

  // Expected outputs straight from the reference queue contents.
  function automatic logic [OW-1:0] model_obs();
    logic [DN-1:0]    v;
    logic [DN*DW-1:0] d;
    v = '0;
    d = '0;
    for (int i = 0; i < DN; i++) begin
      if (mq.size() > i) begin
        v[i] = 1'b1;
        d[i*DW +: DW] = mq[i];
      end
    end
    return {4'(mq.size()), mq.size() == 0, mq.size() == DEPTH,
            (DEPTH - mq.size()) >= EN, v, d};
  endfunction

  // Apply one clock edge to both the model and the DUT.
  task automatic tick();
    int ne, nd;
    logic [1:0] both;
    if (rst || flush) begin
      mq.delete();
    end else begin
      ne = ((DEPTH - mq.size()) >= EN) ? lead(enq_valid) : 0;
      for (int i = 0; i < DN; i++) both[i] = (mq.size() > i) && deq_ready[i];
      nd = pause ? 0 : lead(both);
      repeat (nd) void'(mq.pop_front());
      for (int k = 0; k < ne; k++) mq.push_back(enq_data[k*DW +: DW]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 1'b0; pause = 1'b0; enq_valid = 2'b00; deq_ready = 2'b00;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; pause = 1'b0; deq_ready = 2'b00;
    enq_valid = 2'b11; enq_data = {rnd(), rnd()};
    tick(); tick();
    rst = 1'b0; enq_valid = 2'b00;
    n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", full); end
    n_cmp++; if (enq_ready !== 1'b1) begin n_err++; $display("FAIL reset_enq_ready: got %b want 1", enq_ready); end
    n_cmp++; if (deq_valid !== 2'b00) begin n_err++; $display("FAIL reset_deq_valid: got %b want 00", deq_valid); end
    n_cmp++; if (deq_data !== '0) begin n_err++; $display("FAIL reset_deq_data: got %h want 0", deq_data); end
  endtask

  task automatic test_fill_full();
    logic [DW-1:0] a[10];
    for (int i = 0; i < 10; i++) a[i] = rnd();
    for (int c = 0; c < 4; c++) begin
      enq_valid = 2'b11; enq_data = {a[2*c+1], a[2*c]}; tick();
    end
    enq_valid = 2'b00;
    n_cmp++; if (count !== 4'd8) begin n_err++; $display("FAIL fill_count: got %0d want 8", count); end
    n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL fill_full: got %b want 1", full); end
    n_cmp++; if (enq_ready !== 1'b0) begin n_err++; $display("FAIL fill_enq_ready: got %b want 0", enq_ready); end
    enq_valid = 2'b11; enq_data = {a[9], a[8]}; tick();
    enq_valid = 2'b00;
    n_cmp++; if (count !== 4'd8) begin n_err++; $display("FAIL fill_reject_count: got %0d want 8", count); end
    n_cmp++; if (deq_data[DW-1:0] !== a[0]) begin n_err++; $display("FAIL fill_head: got %h want %h", deq_data[DW-1:0], a[0]); end
    n_cmp++; if (dut_obs !== model_obs()) begin n_err++; $display("FAIL fill_model: got %h want %h", dut_obs, model_obs()); end
    flush = 1'b1; tick(); flush = 1'b0;
  endtask

  task automatic test_partial();
    logic [DW-1:0] a, b, c, d;
    a = rnd(); b = rnd(); c = rnd(); d = rnd();
    enq_valid = 2'b11; enq_data = {b, a}; tick();
    enq_valid = 2'b01; enq_data = {d, c}; tick();
    enq_valid = 2'b10; enq_data = {rnd(), rnd()}; tick();
    enq_valid = 2'b00;
    n_cmp++; if (count !== 4'd3) begin n_err++; $display("FAIL partial_enq_count: got %0d want 3", count); end
    deq_ready = 2'b01; tick(); deq_ready = 2'b00;
    n_cmp++; if (deq_data[DW-1:0] !== b) begin n_err++; $display("FAIL partial_lane0: got %h want %h", deq_data[DW-1:0], b); end
    n_cmp++; if (deq_data[DW +: DW] !== c) begin n_err++; $display("FAIL partial_lane1: got %h want %h", deq_data[DW +: DW], c); end
    n_cmp++; if (count !== 4'd2) begin n_err++; $display("FAIL partial_count: got %0d want 2", count); end
    flush = 1'b1; tick(); flush = 1'b0;
  endtask

  task automatic test_simultaneous();
    for (int c = 0; c < 3; c++) begin
      enq_valid = 2'b11; enq_data = {rnd(), rnd()}; tick();
    end
    n_cmp++; if (count !== 4'd6) begin n_err++; $display("FAIL simul_pre_count: got %0d want 6", count); end
    enq_valid = 2'b11; deq_ready = 2'b11; enq_data = {rnd(), rnd()}; tick();
    n_cmp++; if (count !== 4'd6) begin n_err++; $display("FAIL simul6_count: got %0d want 6", count); end
    n_cmp++; if (dut_obs !== model_obs()) begin n_err++; $display("FAIL simul6_model: got %h want %h", dut_obs, model_obs()); end
    enq_valid = 2'b01; deq_ready = 2'b00; enq_data = {rnd(), rnd()}; tick();
    n_cmp++; if (enq_ready !== 1'b0) begin n_err++; $display("FAIL simul7_enq_ready: got %b want 0", enq_ready); end
    enq_valid = 2'b11; deq_ready = 2'b11; enq_data = {rnd(), rnd()}; tick();
    n_cmp++; if (count !== 4'd5) begin n_err++; $display("FAIL simul7_count: got %0d want 5", count); end
    n_cmp++; if (dut_obs !== model_obs()) begin n_err++; $display("FAIL simul7_model: got %h want %h", dut_obs, model_obs()); end
    idle_inputs(); flush = 1'b1; tick(); flush = 1'b0;
  endtask

  task automatic test_wrap_pause();
    logic [DW-1:0] got[$];
    logic [DW-1:0] pre;
    logic          pv, p;
    int            idx, cyc, n;
    idx = 0; cyc = 0;
    while (got.size() < 20 && cyc < 400) begin
      cyc++;
      pause     = ($urandom_range(0, 3) == 0);
      deq_ready = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b01;
      if (idx >= 20) enq_valid = 2'b00;
      else enq_valid = 2'($urandom_range(0, 3));
      if (idx == 19) enq_valid[1] = 1'b0;
      enq_data = {val(idx + 1), val(idx)};
      n_cmp++; if (dut_obs !== model_obs()) begin n_err++; $display("FAIL wrap_model cyc %0d: got %h want %h", cyc, dut_obs, model_obs()); end
      n = pause ? 0 : lead(deq_valid & deq_ready);
      for (int i = 0; i < n; i++) got.push_back(deq_data[i*DW +: DW]);
      if ((DEPTH - mq.size()) >= EN) idx += lead(enq_valid);
      pre = deq_data[DW-1:0]; pv = deq_valid[0]; p = pause;
      tick();
      if (p && pv) begin
        n_cmp++; if (deq_data[DW-1:0] !== pre) begin n_err++; $display("FAIL pause_head cyc %0d: got %h want %h", cyc, deq_data[DW-1:0], pre); end
      end
    end
    idle_inputs();
    n_cmp++; if (got.size() != 20) begin n_err++; $display("FAIL wrap_drain_count: got %0d want 20 within cycle budget", got.size()); end
    for (int i = 0; i < got.size() && i < 20; i++) begin
      n_cmp++; if (got[i] !== val(i)) begin n_err++; $display("FAIL wrap_order[%0d]: got %h want %h", i, got[i], val(i)); end
    end
  endtask

  task automatic test_flush();
    logic [DW-1:0] x;
    enq_valid = 2'b11; enq_data = {rnd(), rnd()}; tick();
    enq_data = {rnd(), rnd()}; tick();
    enq_valid = 2'b01; enq_data = {rnd(), rnd()}; tick();
    n_cmp++; if (count !== 4'd5) begin n_err++; $display("FAIL flush_pre_count: got %0d want 5", count); end
    flush = 1'b1; enq_valid = 2'b11; deq_ready = 2'b11; enq_data = {rnd(), rnd()}; tick();
    idle_inputs();
    n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL flush_count: got %0d want 0", count); end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL flush_empty: got %b want 1", empty); end
    n_cmp++; if (deq_valid !== 2'b00) begin n_err++; $display("FAIL flush_deq_valid: got %b want 00", deq_valid); end
    n_cmp++; if (enq_ready !== 1'b1) begin n_err++; $display("FAIL flush_enq_ready: got %b want 1", enq_ready); end
    x = rnd();
    enq_valid = 2'b01; enq_data = {rnd(), x}; tick();
    enq_valid = 2'b00;
    n_cmp++; if (deq_valid !== 2'b01) begin n_err++; $display("FAIL flush_resume_valid: got %b want 01", deq_valid); end
    n_cmp++; if (deq_data[DW-1:0] !== x) begin n_err++; $display("FAIL flush_resume_data: got %h want %h", deq_data[DW-1:0], x); end
    n_cmp++; if (dut_obs !== model_obs()) begin n_err++; $display("FAIL flush_model: got %h want %h", dut_obs, model_obs()); end
  endtask

  initial begin
    test_reset();
    test_fill_full();
    test_partial();
    test_simultaneous();
    test_wrap_pause();
    test_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
